// File: rtl/conv_mem_sequencer.sv
// conv_mem_sequencer: runs one 3x3 filter over a 4x4 input held in the shared
// main memory and writes the four saturated 2x2 results into a chosen output
// region. The filter is fetched once into local registers. Each output pixel
// then streams nine input reads through a multiply-accumulate, followed by one
// write. All memory-side outputs are registered.
module conv_mem_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        bank_sel,
  input  logic [DATA_W-1:0] mem_out_A,
  input  logic [DATA_W-1:0] mem_out_F,
  output logic [5:0]        mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [1:0]        en_INPUT,
  output logic [1:0]        en_FILTER,
  output logic [1:0]        en_OUT1,
  output logic [1:0]        en_OUT2,
  output logic [1:0]        en_OUT3,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0]       EN_OFF  = 2'b00;
  localparam logic [1:0]       EN_RD   = 2'b10;
  localparam logic [1:0]       EN_WR   = 2'b11;
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((1 << DATA_W) - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_F, S_CONV, S_DONE} state_t;

  state_t            state;
  // LOAD_F: 0..8 issue filter reads, 9 drain.
  // CONV:   0..8 issue taps, 9 drain, 10 write.
  logic [3:0]        cnt;
  logic [1:0]        pix;
  logic [1:0]        bank;
  logic [DATA_W-1:0] f_reg [9];
  logic [ACC_W-1:0]  acc;

  // Read data always belongs to the tap issued one cycle earlier.
  logic [3:0]          tap_rd;
  logic [DATA_W-1:0]   f_cur;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc_nxt;
  logic [DATA_W-1:0]   sat_nxt;

  assign tap_rd  = cnt - 4'd1;
  assign f_cur   = (tap_rd < 4'd9) ? f_reg[tap_rd] : '0;
  assign prod    = {{DATA_W{1'b0}}, mem_out_A} * {{DATA_W{1'b0}}, f_cur};
  assign acc_nxt = acc + ACC_W'(prod);
  // The write data is built from acc_nxt. That lets the write issue in the
  // cycle right after the final tap's data arrives.
  assign sat_nxt = (acc_nxt > SAT_MAX) ? '1 : acc_nxt[DATA_W-1:0];

  // Input address of tap k = 3i+j for pixel p = 2r+c is (r+i)*4 + (c+j).
  function automatic logic [5:0] tap_addr(input logic [1:0] p, input logic [3:0] k);
    logic [5:0] off;
    case (k)
      4'd0:    off = 6'd0;
      4'd1:    off = 6'd1;
      4'd2:    off = 6'd2;
      4'd3:    off = 6'd4;
      4'd4:    off = 6'd5;
      4'd5:    off = 6'd6;
      4'd6:    off = 6'd8;
      4'd7:    off = 6'd9;
      default: off = 6'd10;
    endcase
    return {3'b000, p[1], 1'b0, p[0]} + off;
  endfunction

  // Sequencer FSM. All bus outputs are registered, and default to idle every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pix       <= '0;
      bank      <= '0;
      acc       <= '0;
      for (int i = 0; i < 9; i++) f_reg[i] <= '0;
      mem_addr  <= '0;
      mem_data  <= '0;
      en_INPUT  <= EN_OFF;
      en_FILTER <= EN_OFF;
      en_OUT1   <= EN_OFF;
      en_OUT2   <= EN_OFF;
      en_OUT3   <= EN_OFF;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      en_INPUT  <= EN_OFF;
      en_FILTER <= EN_OFF;
      en_OUT1   <= EN_OFF;
      en_OUT2   <= EN_OFF;
      en_OUT3   <= EN_OFF;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (bank_sel == 2'd3) begin
              err <= 1'b1;
            end else begin
              state     <= S_LOAD_F;
              bank      <= bank_sel;
              cnt       <= '0;
              busy      <= 1'b1;
              mem_addr  <= 6'd16;
              en_FILTER <= EN_RD;
            end
          end
        end
        S_LOAD_F: begin
          if (cnt != 4'd0) f_reg[tap_rd] <= mem_out_F;
          if (cnt == 4'd9) begin
            state    <= S_CONV;
            cnt      <= '0;
            pix      <= '0;
            mem_addr <= tap_addr(2'd0, 4'd0);
            en_INPUT <= EN_RD;
          end else begin
            cnt <= cnt + 4'd1;
            if (cnt != 4'd8) begin
              mem_addr  <= 6'd17 + {2'b00, cnt};
              en_FILTER <= EN_RD;
            end
          end
        end
        S_CONV: begin
          if (cnt == 4'd0)       acc <= '0;
          else if (cnt <= 4'd9)  acc <= acc_nxt;
          if (cnt < 4'd8) begin
            cnt      <= cnt + 4'd1;
            mem_addr <= tap_addr(pix, cnt + 4'd1);
            en_INPUT <= EN_RD;
          end else if (cnt == 4'd8) begin
            cnt <= 4'd9;
          end else if (cnt == 4'd9) begin
            cnt      <= 4'd10;
            mem_addr <= 6'd25 + {2'b00, bank, 2'b00} + {4'b0000, pix};
            mem_data <= sat_nxt;
            case (bank)
              2'd0:    en_OUT1 <= EN_WR;
              2'd1:    en_OUT2 <= EN_WR;
              default: en_OUT3 <= EN_WR;
            endcase
          end else if (pix == 2'd3) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            pix      <= pix + 2'd1;
            cnt      <= '0;
            mem_addr <= tap_addr(pix + 2'd1, 4'd0);
            en_INPUT <= EN_RD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
